// File: rtl/gate_pipe_credit_fifo_if.sv
// Handshake bundle between the gated pipeline, its issuing logic and the consumer.
// The master side drives issue/arrival/ready; the slave side is the credit FIFO.
interface gate_pipe_credit_fifo_if #(
    parameter int WIDTH = 1
);
    logic             issue_valid;
    logic             can_issue;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output issue_valid, in_valid, in_data, out_ready,
        input  can_issue, out_valid, out_data
    );

    modport slave (
        input  issue_valid, in_valid, in_data, out_ready,
        output can_issue, out_valid, out_data
    );
endinterface

// File: rtl/gate_pipe_credit_fifo.sv
// Output FIFO behind a fixed-latency, no-backpressure pipeline. Credits cover both
// buffered entries and beats still in flight, so legal upstream traffic never overflows.
module gate_pipe_credit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    gate_pipe_credit_fifo_if.slave     bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       error
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   CREDITS  = (CW + 1)'(DEPTH);

    // Small storage read asynchronously so the head is visible the cycle after a push.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic          error_reg, error_next;

    logic          push, pop, full, wr_en;
    logic [CW:0]   credits_used;

    assign full         = (count_reg == FULL);
    assign push         = bus.in_valid;
    assign pop          = bus.out_valid & bus.out_ready;
    assign wr_en        = push & (~full | pop);
    assign credits_used = {1'b0, count_reg} + {1'b0, inflight_reg};

    // Registered state only: no same-cycle credit for a pop.
    assign bus.can_issue = (credits_used < CREDITS);
    assign bus.out_valid = (count_reg != '0);
    assign bus.out_data  = mem[rd_ptr_reg];
    assign count         = count_reg;
    assign error         = error_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        inflight_next = inflight_reg;
        error_next    = error_reg;

        if (wr_en) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (bus.issue_valid && !bus.in_valid) begin
            inflight_next = (inflight_reg == FULL) ? inflight_reg : inflight_reg + 1'b1;
        end else if (!bus.issue_valid && bus.in_valid) begin
            inflight_next = (inflight_reg == '0) ? '0 : inflight_reg - 1'b1;
        end

        if ((push && full && !pop) ||
            (bus.in_valid && inflight_reg == '0) ||
            (bus.issue_valid && !bus.can_issue)) begin
            error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            error_reg    <= error_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_reg] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_gate_pipe_credit_fifo.sv
// Directed bench with a 2-cycle upstream latency model; expected beats are queued at
// issue time and a negedge monitor checks every pop against that queue.
module tb_gate_pipe_credit_fifo;
    localparam int DEPTH = 4;
    localparam int WIDTH = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       count;
    logic             error;

    gate_pipe_credit_fifo_if #(.WIDTH(WIDTH)) bus ();

    gate_pipe_credit_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count),
        .error (error)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_want;

    // Upstream pipeline model: two stages of valid/data.
    logic             pv0 = 1'b0;
    logic             pv1 = 1'b0;
    logic [WIDTH-1:0] pd0 = '0;
    logic [WIDTH-1:0] pd1 = '0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Drive one cycle's inputs, then step past the next rising edge.
    task automatic tick_full(input logic iss, input logic [WIDTH-1:0] d, input logic rdy,
                             input logic inj, input logic [WIDTH-1:0] inj_d, input logic keep);
        bus.issue_valid = iss;
        bus.out_ready   = rdy;
        bus.in_valid    = pv1 | inj;
        bus.in_data     = inj ? inj_d : pd1;
        pv1 = pv0;
        pd1 = pd0;
        pv0 = iss;
        pd0 = d;
        if (keep && iss) exp_q.push_back(d);
        if (keep && inj) exp_q.push_back(inj_d);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic iss, input logic [WIDTH-1:0] d, input logic rdy);
        tick_full(iss, d, rdy, 1'b0, '0, 1'b1);
    endtask

    task automatic pulse_reset();
        pv0 = 1'b0;
        pv1 = 1'b0;
        exp_q.delete();
        bus.issue_valid = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got data %0d want no pop", bus.out_data);
            end else begin
                mon_want = exp_q.pop_front();
                if (bus.out_data !== mon_want) begin
                    bad++;
                    $display("FAIL pop_data: got %0d want %0d", bus.out_data, mon_want);
                end else begin
                    $display("pop data=%0d ok", bus.out_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset with random inputs for two cycles.
        rst = 1'b1;
        repeat (2) begin
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.in_valid    = 1'($urandom_range(0, 1));
            bus.in_data     = WIDTH'($urandom_range(0, 1));
            bus.out_ready   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        chk("reset_can_issue", bus.can_issue, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_error", error, 0);

        // Fill and drain.
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        chk("fill_can_issue_before_4th", bus.can_issue, 1);
        tick(1, 1, 0);
        chk("fill_can_issue_after_4th", bus.can_issue, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("fill_count", count, 4);
        chk("fill_out_valid", bus.out_valid, 1);
        chk("fill_out_data", bus.out_data, 1);
        chk("fill_can_issue_full", bus.can_issue, 0);
        tick(0, 0, 0);
        chk("fill_out_data_stable", bus.out_data, 1);
        chk("fill_count_stable", count, 4);
        repeat (4) tick(0, 0, 1);
        chk("drain_count", count, 0);
        chk("drain_can_issue", bus.can_issue, 1);
        chk("drain_error", error, 0);
        chk("drain_sb_empty", exp_q.size(), 0);

        // Streaming with wrap-around.
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            if (bus.can_issue) begin
                tick(1, WIDTH'(n % 2 == 0), 1);
                n++;
            end else begin
                tick(0, 0, 1);
            end
        end
        chk("stream_issued", n, 10);
        repeat (6) tick(0, 0, 1);
        chk("stream_count", count, 0);
        chk("stream_error", error, 0);
        chk("stream_sb_empty", exp_q.size(), 0);

        // Simultaneous push and pop at count=2.
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        tick(0, 0, 0);
        chk("simul_setup_count", count, 2);
        tick(0, 0, 1);
        chk("simul_count", count, 2);
        chk("simul_head", bus.out_data, 0);
        repeat (2) tick(0, 0, 1);
        chk("simul_drain_count", count, 0);
        chk("simul_sb_empty", exp_q.size(), 0);

        // Credit violation: fifth issue without a credit; its beat is dropped.
        tick(1, 1, 0);
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        chk("credit_error_before", error, 0);
        tick_full(1, 0, 0, 1'b0, '0, 1'b0);
        chk("credit_error_set", error, 1);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("credit_count_full", count, 4);
        repeat (4) tick(0, 0, 1);
        tick(1, 1, 1);
        repeat (4) tick(0, 0, 1);
        chk("credit_error_sticky", error, 1);
        chk("credit_sb_empty", exp_q.size(), 0);

        // Reset mid-operation at count=3, inflight=1, then a stale arrival.
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 0);
        tick(1, 1, 0);
        tick(0, 0, 0);
        chk("midrst_setup_count", count, 3);
        pulse_reset();
        chk("midrst_count", count, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_can_issue", bus.can_issue, 1);
        chk("midrst_error_clear", error, 0);
        tick_full(0, 0, 0, 1'b1, 1, 1'b1);
        chk("stale_error", error, 1);
        chk("stale_count", count, 1);
        tick(0, 0, 1);
        chk("stale_drain_count", count, 0);
        chk("stale_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_pipe_credit_fifo.md
# gate_pipe_credit_fifo

Credit-tracked output buffer that sits directly downstream of the gated valid-only pipeline. That pipeline has fixed latency and no backpressure, so this block does two things. It buffers the pipeline's output beats in a DEPTH-entry FIFO and presents them to the consumer on a valid/ready interface. It also tells the issuing logic, via `can_issue`, whether a new beat may enter the pipeline without risking loss. Credits count both buffered entries and beats still in flight through the pipeline, so the FIFO can never overflow under legal use.

## Interface
- `DEPTH`, default 4: FIFO entries and total credits; any integer ≥ 2, not required to be a power of two.
- `WIDTH`, default 1: data width of one beat.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `issue_valid` in 1: a beat entered the upstream pipeline this cycle (the pipeline's `input_valid`).
- `can_issue` out 1: a credit is available; upstream may assert `issue_valid` this cycle.
- `in_valid` in 1: pipeline output beat valid (the pipeline's `output_valid`).
- `in_data` in WIDTH: pipeline output beat data.
- `out_valid` out 1: FIFO head valid.
- `out_data` out WIDTH: FIFO head data.
- `out_ready` in 1: consumer accepts the head this cycle.
- `count` out $clog2(DEPTH+1): number of entries currently held in the FIFO.
- `error` out 1: sticky protocol-violation flag.

## Operation
- **State:** storage array `mem[DEPTH]`, `wr_ptr`, `rd_ptr`, `count`, `inflight` (width $clog2(DEPTH+1)), and `error`.
- **Push:** `push = in_valid`.
  - Data is written to `mem[wr_ptr]`.
  - `wr_ptr` advances and wraps from DEPTH-1 to 0.
- **Pop:** `pop = out_valid & out_ready`. `rd_ptr` advances and wraps the same way.
- **Count update:** `count += push - pop`.
  - Simultaneous push and pop leaves `count` unchanged and preserves order.
  - A push when `count == DEPTH` and no pop that cycle drops the data; `count` and `wr_ptr` are unchanged and `error` is set.
- **Inflight update:** `inflight += issue_valid - in_valid`, saturating at 0 and at DEPTH.
  - `in_valid` while `inflight == 0` sets `error`.
  - `issue_valid` while `can_issue == 0` sets `error`. The increment still applies, subject to saturation.
- **can_issue** = `(count + inflight) < DEPTH`.
  - Computed from registered state only; there is no combinational path from `issue_valid`, `in_valid` or `out_ready`.
  - It does not credit a same-cycle pop, so it is conservative by one cycle.
- **out_valid** = `count != 0`.
- **out_data** = `mem[rd_ptr]`. It is don't-care while `out_valid == 0` and must hold stable while `out_valid & !out_ready`.
- **error:** set by any violation above and cleared only by `rst`.
- **Ordering:** beats leave in strict arrival order and none are duplicated.

## Timing
- **Reset:** with `rst` high at a rising edge, the next cycle has:
  - `count=0`, `inflight=0`, `wr_ptr=rd_ptr=0`, `error=0`;
  - hence `out_valid=0` and `can_issue=1`.
  - `mem` contents are not reset.
  - Inputs are ignored while `rst` is high, including in the same cycle as the reset edge.
- **Fill latency:** a beat pushed at edge t shows `out_valid=1` with that data from t+1 onward.
- **Pop:** a pop at edge t presents the next entry, or drops `out_valid` if it was the last one, from t+1.
- **Credit return:** `can_issue` reflects a pop or an arrival one cycle after the edge that performed it.
- **Reset mid-operation:**
  - All buffered and in-flight credits are discarded.
  - The upstream pipeline shares `rst`, so no stale arrivals follow.
  - If a stale arrival does follow, it is flagged through `error`.

## Test plan
All scenarios use DEPTH=4, WIDTH=1, and a 2-cycle upstream latency model driven by the bench.
- **Reset values:** assert `rst` 2 cycles with random inputs -> `can_issue=1`, `out_valid=0`, `count=0`, `error=0`.
- **Fill and drain:**
  - Stimulus: issue 4 beats back-to-back; arrivals follow 2 cycles later with data 1,0,1,1; `out_ready=0`.
  - Required response: `can_issue=0` from the cycle after the 4th issue; `count=4`; `out_data=1` held stable.
  - Then raise `out_ready` for 4 cycles -> pops 1,0,1,1 in order; `count=0`; `can_issue=1`; `error=0`.
- **Streaming wrap-around:**
  - Stimulus: `out_ready=1`; issue 10 beats whenever `can_issue`, data alternating 1,0.
  - Required response: all 10 beats leave in order; pointers wrap at least twice; `error=0`.
- **Simultaneous push and pop:**
  - Stimulus: at `count=2`, `in_valid=1` and `out_ready=1` in the same cycle.
  - Required response: `count` stays 2; the head advances to the next older entry; the new beat is enqueued at the tail.
- **Credit violation:** issue 5 beats with `out_ready=0` -> `error=1` from the cycle after the 5th issue; it stays 1 through subsequent normal traffic until `rst`.
- **Reset mid-operation:**
  - Stimulus: `count=3`, `inflight=1`; pulse `rst` for 1 cycle.
  - Required response: next cycle `count=0`, `out_valid=0`, `can_issue=1`.
  - Then an injected `in_valid` with `inflight=0` -> `error=1`.
